// File: rtl/exc_cp0.sv
// CP0 exception sink: SR/Cause/EPC/PRId, exception vs. interrupt arbitration, flush request.
// Optional EXC_COUNT_EN adds a taken-request counter readable at CP0 register 22.
module exc_cp0 #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL   = 32'h2022_1217
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        is_exc,
   input  logic [4:0]  exc_code,
   input  logic        is_bd,
   input  logic [31:0] vpc,
   input  logic [5:0]  hw_int,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic        eret,
   output logic [31:0] rdata,
   output logic        req,
   output logic [31:0] handler_pc,
   output logic [31:0] epc_out
);

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;
   localparam logic [4:0] CP0_CNT   = 5'd22;

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exccode;
   logic [29:0] r_epc;

   logic        w_int_req;
   logic        w_exc_req;
   logic [29:0] w_victim_epc;
   logic [31:0] w_sr;
   logic [31:0] w_cause;
   logic [31:0] w_epc;
   logic        w_unused;

   // EXL masks both sources, so an exception handler is never re-entered.
   assign w_int_req = r_ie & ~r_exl & (|(hw_int & r_im));
   assign w_exc_req = is_exc & ~r_exl;
   assign req       = w_int_req | w_exc_req;

   // A delay-slot victim restarts at its branch, one word earlier.
   assign w_victim_epc = vpc[31:2] - {29'd0, is_bd};
   assign w_unused     = &{1'b0, vpc[1:0]};

   assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
   assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exccode, 2'b00};
   assign w_epc   = {r_epc, 2'b00};

   assign handler_pc = HANDLER_PC;
   assign epc_out    = w_epc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_im      <= '0;
         r_exl     <= 1'b0;
         r_ie      <= 1'b0;
         r_bd      <= 1'b0;
         r_ip      <= '0;
         r_exccode <= '0;
         r_epc     <= '0;
      end else begin
         r_ip <= hw_int;
         if (req) begin
            r_exl     <= 1'b1;
            r_bd      <= is_bd;
            r_exccode <= w_int_req ? 5'd0 : exc_code;
            r_epc     <= w_victim_epc;
         end else begin
            if (we && (addr == CP0_SR)) begin
               r_im  <= wdata[15:10];
               r_exl <= wdata[1];
               r_ie  <= wdata[0];
            end
            if (we && (addr == CP0_EPC)) begin
               r_epc <= wdata[31:2];
            end
            // Placed after the mtc0 update so eret has the final say on EXL.
            if (eret) begin
               r_exl <= 1'b0;
            end
         end
      end
   end

`ifdef EXC_COUNT_EN
   logic [31:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (req) begin
         r_cnt <= r_cnt + 32'd1;
      end else if (we && (addr == CP0_CNT)) begin
         r_cnt <= wdata;
      end
   end
`endif

   always_comb begin
      rdata = '0;
      case (addr)
         CP0_SR:    rdata = w_sr;
         CP0_CAUSE: rdata = w_cause;
         CP0_EPC:   rdata = w_epc;
         CP0_PRID:  rdata = PRID_VAL;
`ifdef EXC_COUNT_EN
         CP0_CNT:   rdata = r_cnt;
`endif
         default:   rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_exc_cp0.sv
// Scoreboard bench for exc_cp0: stimulus queues expected outputs, a negedge monitor compares them.
module tb_exc_cp0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        is_exc;
   logic [4:0]  exc_code;
   logic        is_bd;
   logic [31:0] vpc;
   logic [5:0]  hw_int;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        eret;
   logic [31:0] rdata;
   logic        req;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;

   localparam int SEL_RDATA = 0;
   localparam int SEL_REQ   = 1;
   localparam int SEL_EPC   = 2;
   localparam int SEL_HPC   = 3;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       nm;
   } chk_t;

   chk_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   exc_cp0 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .is_exc     (is_exc),
      .exc_code   (exc_code),
      .is_bd      (is_bd),
      .vpc        (vpc),
      .hw_int     (hw_int),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .eret       (eret),
      .rdata      (rdata),
      .req        (req),
      .handler_pc (handler_pc),
      .epc_out    (epc_out)
   );

   always #5 clk = ~clk;

   task automatic idle();
      is_exc   = 1'b0;
      exc_code = 5'd0;
      is_bd    = 1'b0;
      vpc      = 32'h0;
      hw_int   = 6'd0;
      we       = 1'b0;
      addr     = 5'd0;
      wdata    = 32'h0;
      eret     = 1'b0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic expect_out(input int sel, input logic [31:0] v, input string nm);
      chk_t c;
      c.sel = sel;
      c.exp = v;
      c.nm  = nm;
      sb.push_back(c);
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] v, input string nm);
      addr = a;
      expect_out(SEL_RDATA, v, nm);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we    = 1'b1;
      addr  = a;
      wdata = d;
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
      is_exc   = 1'b1;
      exc_code = code;
      vpc      = pc;
      is_bd    = bd;
   endtask

   // Monitor: outputs are combinational, so every queued expectation is due this cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = sb.pop_front();
            case (c.sel)
               SEL_RDATA: act = rdata;
               SEL_REQ:   act = {31'd0, req};
               SEL_EPC:   act = epc_out;
               default:   act = handler_pc;
            endcase
            n_vec++;
            if (act !== c.exp) begin
               n_miss++;
               $display("FAIL %s: got %h, want %h", c.nm, act, c.exp);
            end
         end
      end
   end

   initial begin
      logic [31:0] cnt_ff, cnt_zero, cnt_one;
`ifdef EXC_COUNT_EN
      cnt_ff   = 32'hFFFF_FFFF;
      cnt_zero = 32'h0;
      cnt_one  = 32'h1;
`else
      cnt_ff   = 32'h0;
      cnt_zero = 32'h0;
      cnt_one  = 32'h0;
`endif
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      rd(5'd12, 32'h0, "sr_reset");
      expect_out(SEL_REQ, 32'h0, "req_reset");
      expect_out(SEL_EPC, 32'h0, "epc_reset");
      expect_out(SEL_HPC, 32'h0000_4180, "handler_pc");
      nxt(); rd(5'd15, 32'h2022_1217, "prid");
      nxt(); rd(5'd13, 32'h0, "cause_reset");

      // Load SR/EPC, then assert reset mid-cycle with an interrupt pending
      nxt(); wr(5'd12, 32'h0000_FC01); expect_out(SEL_REQ, 32'h0, "req_after_rst");
      nxt(); wr(5'd14, 32'h0000_2223); expect_out(SEL_RDATA, 32'h0, "epc_raw_old");
      nxt(); rd(5'd12, 32'h0000_FC01, "sr_written");
      nxt(); rd(5'd14, 32'h0000_2220, "epc_written");
      nxt(); rst_n = 1'b0; hw_int = 6'b000001; rd(5'd12, 32'h0, "sr_async_rst");
      expect_out(SEL_REQ, 32'h0, "req_async_rst");
      expect_out(SEL_EPC, 32'h0, "epc_async_rst");
      nxt(); rd(5'd13, 32'h0, "cause_async_rst");
      nxt(); rst_n = 1'b1; rd(5'd15, 32'h2022_1217, "prid_after_rst");

      // Plain exception
      nxt(); exc(5'd10, 32'h0000_3010, 1'b0); expect_out(SEL_REQ, 32'h1, "req_plain");
      nxt(); rd(5'd14, 32'h0000_3010, "epc_plain");
      expect_out(SEL_EPC, 32'h0000_3010, "epc_out_plain");
      expect_out(SEL_REQ, 32'h0, "req_idle");
      nxt(); rd(5'd13, 32'h0000_0028, "cause_plain");
      nxt(); rd(5'd12, 32'h0000_0002, "sr_exl_set");
      exc(5'd7, 32'h0000_3100, 1'b0); expect_out(SEL_REQ, 32'h0, "req_masked_exl");

      // Delay-slot exception
      nxt(); eret = 1'b1; expect_out(SEL_REQ, 32'h0, "req_eret");
      nxt(); rd(5'd12, 32'h0, "sr_eret");
      nxt(); exc(5'd4, 32'h0000_3018, 1'b1); expect_out(SEL_REQ, 32'h1, "req_bd");
      nxt(); rd(5'd14, 32'h0000_3014, "epc_bd");
      nxt(); rd(5'd13, 32'h8000_0010, "cause_bd");
      nxt(); exc(5'd4, 32'h0000_3020, 1'b0); expect_out(SEL_REQ, 32'h0, "req_nested");
      rd(5'd12, 32'h0000_0002, "sr_bd");

      // Interrupt priority over a simultaneous exception
      nxt(); wr(5'd12, 32'h0000_0401); expect_out(SEL_REQ, 32'h0, "req_sr_wr");
      nxt(); hw_int = 6'b000001; exc(5'd12, 32'h0000_3020, 1'b0);
      rd(5'd12, 32'h0000_0401, "sr_int_setup");
      expect_out(SEL_REQ, 32'h1, "req_int");
      nxt(); rd(5'd13, 32'h0000_0400, "cause_int");
      expect_out(SEL_EPC, 32'h0000_3020, "epc_int");
      nxt(); rd(5'd12, 32'h0000_0403, "sr_int");

      // Interrupt masked by IM=0
      nxt(); wr(5'd12, 32'h0000_0001);
      nxt(); hw_int = 6'b000001; rd(5'd12, 32'h0000_0001, "sr_im0");
      expect_out(SEL_REQ, 32'h0, "req_im0");
      nxt(); hw_int = 6'b000001; rd(5'd13, 32'h0000_0400, "cause_ip_only");
      expect_out(SEL_REQ, 32'h0, "req_im0_b");

      // Write suppression, eret, mtc0+eret, eret+req
      nxt(); exc(5'd8, 32'h0000_3030, 1'b0); we = 1'b1; wdata = 32'h0000_FC00; addr = 5'd12;
      expect_out(SEL_REQ, 32'h1, "req_suppress");
      nxt(); rd(5'd12, 32'h0000_0003, "sr_suppress");
      expect_out(SEL_EPC, 32'h0000_3030, "epc_suppress");
      nxt(); eret = 1'b1; expect_out(SEL_REQ, 32'h0, "req_eret2");
      nxt(); rd(5'd12, 32'h0000_0001, "sr_eret2");
      nxt(); wr(5'd12, 32'h0000_0403); eret = 1'b1;
      nxt(); rd(5'd12, 32'h0000_0401, "sr_mtc0_eret");
      nxt(); exc(5'd3, 32'h0000_3040, 1'b0); eret = 1'b1;
      expect_out(SEL_REQ, 32'h1, "req_eret_req");
      nxt(); rd(5'd12, 32'h0000_0403, "sr_eret_req");

      // Read-only Cause, EPC low bits, unimplemented address
      nxt(); wr(5'd13, 32'hFFFF_FFFF);
      nxt(); rd(5'd13, 32'h0000_000C, "cause_ro");
      nxt(); wr(5'd14, 32'h1234_5677); expect_out(SEL_RDATA, 32'h0000_3040, "epc_raw");
      nxt(); rd(5'd14, 32'h1234_5674, "epc_mtc0");
      expect_out(SEL_EPC, 32'h1234_5674, "epc_out_mtc0");
      nxt(); rd(5'd5, 32'h0, "unimpl");

      // Request counter (reads 0 when absent)
      nxt(); eret = 1'b1;
      nxt(); wr(5'd22, 32'hFFFF_FFFF);
      nxt(); rd(5'd22, cnt_ff, "cnt_load");
      nxt(); exc(5'd1, 32'h0000_3050, 1'b0); rd(5'd22, cnt_ff, "cnt_pre");
      expect_out(SEL_REQ, 32'h1, "req_cnt");
      nxt(); rd(5'd22, cnt_zero, "cnt_wrap");
      nxt(); eret = 1'b1;
      nxt(); exc(5'd1, 32'h0000_3060, 1'b0); wr(5'd22, 32'h0000_0100);
      nxt(); rd(5'd22, cnt_one, "cnt_inc_wins");

      nxt();
      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
